// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB3 bridge: one command in, one APB transfer, one response out.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   cmd_fire;
    logic   rsp_fire;
    logic   access_done;
    logic   timed_out;

    // Both channels transfer on a cycle where valid && ready; valid never waits on ready.
    assign cmd_ready   = (state == IDLE) && !RST;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign rsp_valid   = (state == RESP);
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign PSEL        = (state == SETUP) || (state == ACCESS);
    assign PENABLE     = (state == ACCESS);
    assign access_done = (state == ACCESS) && PREADY;
    assign state_dbg   = state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // The cycle that would bring the count to TIMEOUT_CYCLES is the last ACCESS cycle.
    assign timed_out = (state == ACCESS) && !PREADY && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done || timed_out) state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (access_done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (timed_out) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus randomized transfers against a phase/timing model.
// Define APB_MASTER_TIMEOUT_EN for both bench and design to exercise the timeout build.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [DW-1:0] PRDATA;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected responses {rsp_err, rsp_rdata}, in command order.
    logic [DW:0] exp_q[$];

    apb_cmd_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_completer;
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
    endtask

    // One full command: offered now (DUT must be idle), completer inserts `waits` wait states.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input logic err, input logic [DW-1:0] rdata,
                           input int rsp_delay, input logic keep);
        int          c;
        bit          done;
        logic [2:0]  exp_bus;
        logic [DW:0] exp;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        rsp_ready = 1'b0;
        rand_completer();
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        else n_pass++;
        exp_q.push_back({err, wr ? {DW{1'b0}} : rdata});
        c    = 0;
        done = 0;
        while (!done && c < waits + 40) begin
            step();
            c++;
            cmd_valid = keep;
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            if (c >= 2 && c <= 2 + waits) begin
                PREADY  = (c == 2 + waits);
                PSLVERR = (c == 2 + waits) ? err : 1'($urandom_range(0, 1));
                PRDATA  = (c == 2 + waits) ? rdata : $urandom;
            end else begin
                rand_completer();
            end
            if (c == 1) exp_bus = 3'b100;
            else if (c <= 2 + waits) exp_bus = 3'b110;
            else exp_bus = 3'b001;
            n_checks++;
            if ({PSEL, PENABLE, rsp_valid} !== exp_bus)
                $display("FAIL phase c=%0d: got psel/pen/rspv=%b want %b", c, {PSEL, PENABLE, rsp_valid}, exp_bus);
            else n_pass++;
            n_checks++;
            if (cmd_ready !== 1'b0) $display("FAIL cmd_ready_busy c=%0d: got %b want 0", c, cmd_ready);
            else n_pass++;
            if (c <= 2 + waits) begin
                n_checks++;
                if ({PWRITE, PADDR, PWDATA} !== {wr, addr, wdata})
                    $display("FAIL apb_fields c=%0d: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                             c, PWRITE, PADDR, PWDATA, wr, addr, wdata);
                else n_pass++;
            end
            if (rsp_valid === 1'b1) done = 1;
        end
        n_checks++;
        if (!done || c != 3 + waits) begin
            $display("FAIL latency: got %0d (seen=%0d) want %0d", c, done, 3 + waits);
            if (!done) begin
                void'(exp_q.pop_front());
                return;
            end
        end else n_pass++;
        exp = exp_q[0];
        for (int i = 0; i < rsp_delay; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, cmd_ready} !== {1'b1, exp, 3'b000})
                $display("FAIL rsp_stall i=%0d: got v=%b e=%b d=%h bus=%b rdy=%b want v=1 e=%b d=%h bus=00 rdy=0",
                         i, rsp_valid, rsp_err, rsp_rdata, {PSEL, PENABLE}, cmd_ready, exp[DW], exp[DW-1:0]);
            else n_pass++;
            step();
            cmd_addr = $urandom;
            rand_completer();
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {1'b1, exp, 1'b0})
            $display("FAIL rsp_data: got v=%b e=%b d=%h rdy=%b want v=1 e=%b d=%h rdy=0",
                     rsp_valid, rsp_err, rsp_rdata, cmd_ready, exp[DW], exp[DW-1:0]);
        else n_pass++;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001)
            $display("FAIL idle_after: got psel/pen/rspv/rdy=%b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
        else n_pass++;
    endtask

    task automatic test_reset;
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        repeat (3) step();
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        else n_pass++;
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, rsp_rdata} !== '0)
            $display("FAIL reset_outputs: got psel=%b pen=%b pw=%b rv=%b re=%b pa=%h pd=%h rd=%h want all 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, rsp_rdata);
        else n_pass++;
        RST = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_zero_wait;
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, $urandom, 0, 1'b0);
    endtask

    task automatic test_read_wait;
        do_xfer(1'b0, 32'h04, $urandom, 4, 1'b0, 32'h12345678, 0, 1'b0);
    endtask

    task automatic test_err_backpressure;
        // cmd_valid stays high through the stall, so a follow-up command is taken straight after.
        do_xfer(1'b0, $urandom, $urandom, 0, 1'b1, $urandom, 5, 1'b1);
        do_xfer(1'b1, $urandom, $urandom, 1, 1'b0, $urandom, 0, 1'b0);
    endtask

    task automatic test_reset_mid_access;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = $urandom;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) $display("FAIL pre_reset_access: got %b want 11", {PSEL, PENABLE});
        else n_pass++;
        RST = 1'b1;
        step();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000)
            $display("FAIL mid_reset: got psel/pen/rspv/rdy=%b want 0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
        else n_pass++;
        RST = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL mid_reset_release: got %b want 1", cmd_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            rand_completer();
            n_checks++;
            if ({PSEL, PENABLE, rsp_valid} !== 3'b000)
                $display("FAIL mid_reset_quiet i=%0d: got %b want 000", i, {PSEL, PENABLE, rsp_valid});
            else n_pass++;
        end
        PREADY = 1'b0;
    endtask

    task automatic test_timeout;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        PREADY    = 1'b0;
        PRDATA    = $urandom;
        step();
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            step();
            n_checks++;
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110)
                $display("FAIL timeout_access i=%0d: got %b want 110", i, {PSEL, PENABLE, rsp_valid});
            else n_pass++;
        end
        step();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, {DW{1'b0}}})
            $display("FAIL timeout_rsp: got bus/v/e=%b d=%h want 0011 d=0",
                     {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
        else n_pass++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL timeout_idle: got %b want 1", cmd_ready);
        else n_pass++;
`else
        repeat (1000) step();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110)
            $display("FAIL no_timeout: got %b want 110", {PSEL, PENABLE, rsp_valid});
        else n_pass++;
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL no_timeout_exit: got %b want 1", cmd_ready);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++)
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), $urandom, 0, (i < 2));
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++)
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), (i < 15) && ($urandom_range(0, 1) == 1));
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_err_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
